aes_key_sched_stream: RTL and testbench

- Sequential on-the-fly AES-128 key expansion. Feeds the AddRoundKey stage that consumes the mix_columns output.
- Accepts one 128-bit cipher key per start pulse and emits round keys 0..10, one per valid/ready handshake.
- Only the current round key is held, so no 176-byte expanded-key store is needed.
- Byte packing matches the round datapath: byte i occupies bits [8*i+7:8*i]; word j is bytes 4j..4j+3, with byte 4j in the low lane.

---
 rtl/aes_key_sched_stream.sv | 191 +++++++++++++++++++
 tb/tb_aes_key_sched_stream.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched_stream.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_sched_stream
// Purpose  : On-the-fly AES-128 key expansion. Takes one cipher key per start
//            pulse and streams round keys 0..10 over a valid/ready handshake,
//            holding only the current round key.
// Ports    : clk, rst_n            clock, async active-low reset
//            start, key_in         begin expansion of key_in (IDLE only)
//            abort                 synchronous cancel of the current run
//            rk_valid, rk_ready    round-key handshake
//            rk, rk_idx            current round key and its index 0..10
//            busy                  run in progress
//            done                  one-cycle pulse after the round-10 transfer
// Byte i of any 128-bit value sits at bits [8*i+7:8*i]; word j = bytes 4j..4j+3.
// Revision : 1.0  initial release
// ============================================================================
module aes_key_sched_stream #(
  parameter int SBOX_PIPE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         abort,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_idx,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] c_LAST_IDX = 4'd10;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = gf_mul2(sh);
    end
    return acc;
  endfunction

  // S-box computed algebraically: inverse as x^254 (0 maps to 0), then the
  // affine transform expressed as XOR of left rotations by 0..4 plus 0x63.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_CALC = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [127:0]   rk_q, rk_d;
  logic [3:0]     idx_q, idx_d;
  logic [7:0]     rcon_q, rcon_d;
  logic           done_q, done_d;

  logic           w_xfer;
  logic           w_last;
  logic [31:0]    w_rot;
  logic [31:0]    w_sub;
  logic [31:0]    w_t_src;
  logic [31:0]    w_t;
  logic [31:0]    w_n0, w_n1, w_n2, w_n3;
  logic [127:0]   w_next;

  assign rk_valid = (state_q == ST_EMIT);
  assign busy     = (state_q != ST_IDLE);
  assign rk       = rk_q;
  assign rk_idx   = idx_q;
  assign done     = done_q;

  assign w_xfer = rk_valid & rk_ready;
  assign w_last = (idx_q == c_LAST_IDX);

  // RotWord(b12,b13,b14,b15) -> (b13,b14,b15,b12), b13 landing in lane 0.
  assign w_rot = {rk_q[103:96], rk_q[127:104]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign w_sub[8*i +: 8] = sbox(w_rot[8*i +: 8]);
  end

  if (SBOX_PIPE != 0) begin : g_pipe
    logic [31:0] sub_q;
    // Captured on the transfer that leaves EMIT; rk_q is unchanged through
    // the following CALC cycle, so sub_q still matches it there.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sub_q <= '0;
      end else if (w_xfer && !w_last) begin
        sub_q <= w_sub;
      end
    end
    assign w_t_src = sub_q;
  end else begin : g_comb
    assign w_t_src = w_sub;
  end

  assign w_t    = w_t_src ^ {24'h000000, rcon_q};
  assign w_n0   = rk_q[31:0]   ^ w_t;
  assign w_n1   = rk_q[63:32]  ^ w_n0;
  assign w_n2   = rk_q[95:64]  ^ w_n1;
  assign w_n3   = rk_q[127:96] ^ w_n2;
  assign w_next = {w_n3, w_n2, w_n1, w_n0};

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rk_d    = key_in;
          idx_d   = 4'd0;
          rcon_d  = 8'h01;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (w_xfer) begin
          if (w_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (SBOX_PIPE == 0) begin
            rk_d   = w_next;
            idx_d  = idx_q + 4'd1;
            rcon_d = gf_mul2(rcon_q);
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        rk_d    = w_next;
        idx_d   = idx_q + 4'd1;
        rcon_d  = gf_mul2(rcon_q);
        state_d = ST_EMIT;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort outranks start and any transfer in the same cycle.
    if (abort) begin
      state_d = ST_IDLE;
      rk_d    = rk_q;
      idx_d   = idx_q;
      rcon_d  = rcon_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rk_q    <= '0;
      idx_q   <= 4'd0;
      rcon_q  <= 8'h01;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_sched_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_key_sched_stream
// Purpose  : Self-checking bench for aes_key_sched_stream. Runs a combinational
//            (SBOX_PIPE=0) and a pipelined (SBOX_PIPE=1) instance side by side
//            on shared stimulus and compares both against a FIPS-197 style
//            key-expansion model plus a handshake-level expectation model.
// Revision : 1.0  initial release
// ============================================================================
module tb_aes_key_sched_stream;

  localparam logic [127:0] c_FIPS = 128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b;
  localparam logic [127:0] c_K1   = 128'h05766c2a_3939a323_b12c5488_17fefaa0;
  localparam logic [127:0] c_K10  = 128'ha60c63b6_c80c3fe1_8925eec9_a8f914d0;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         abort;
  logic         rk_ready;

  logic         v0, v1, busy0, busy1, done0, done1;
  logic [127:0] rk0, rk1;
  logic [3:0]   idx0, idx1;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]   sbox_tab [256];
  logic [127:0] ktab     [2][11];
  int           n_exp    [2];
  bit           act      [2];
  bit           bub      [2];
  bit           dexp     [2];

  aes_key_sched_stream #(.SBOX_PIPE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .abort(abort),
    .rk_valid(v0), .rk_ready(rk_ready), .rk(rk0), .rk_idx(idx0),
    .busy(busy0), .done(done0)
  );

  aes_key_sched_stream #(.SBOX_PIPE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .abort(abort),
    .rk_valid(v1), .rk_ready(rk_ready), .rk(rk1), .rk_idx(idx1),
    .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // GF(2^8) multiply by shift-and-add with reduction by 0x11b.
  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    int p, x, y;
    p = 0; x = a; y = b;
    while (y != 0) begin
      if ((y & 1) != 0) p = p ^ x;
      x = x << 1;
      if ((x & 'h100) != 0) x = x ^ 'h11b;
      y = y >> 1;
    end
    return p[7:0];
  endfunction

  // S-box table: inverse found by search, then the bitwise affine formula.
  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (tb_mul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_tab[x] = s;
    end
  endtask

  // Full 44-word expansion, then repacked into 11 round keys for lane d.
  task automatic expand(input int d, input logic [127:0] key);
    logic [7:0] w [44][4];
    logic [7:0] t [4];
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++)
      for (int b = 0; b < 4; b++) w[i][b] = key[32*i+8*b +: 8];
    for (int i = 4; i < 44; i++) begin
      for (int b = 0; b < 4; b++) t[b] = w[i-1][b];
      if (i % 4 == 0) begin
        for (int b = 0; b < 4; b++) t[b] = sbox_tab[w[i-1][(b+1)%4]];
        t[0] = t[0] ^ rc;
        rc = tb_mul(rc, 8'h02);
      end
      for (int b = 0; b < 4; b++) w[i][b] = w[i-4][b] ^ t[b];
    end
    for (int r = 0; r < 11; r++)
      for (int j = 0; j < 4; j++)
        for (int b = 0; b < 4; b++) ktab[d][r][32*j+8*b +: 8] = w[4*r+j][b];
  endtask

  // Per-cycle expectation for lane d: checks this cycle, then advances the
  // model using the inputs the DUT will sample at the next rising edge.
  task automatic mon_step(input int d, input logic v, input logic [127:0] k,
                          input logic [3:0] ix, input logic b, input logic dn);
    string p;
    logic  exp_v;
    p = (d == 0) ? "p0" : "p1";
    if (!rst_n) begin
      check_eq({p, "_rst_valid"}, v, 0);
      check_eq({p, "_rst_busy"}, b, 0);
      check_eq({p, "_rst_done"}, dn, 0);
      check_eq({p, "_rst_rk"}, k, 0);
      check_eq({p, "_rst_idx"}, ix, 0);
      act[d] = 0; bub[d] = 0; dexp[d] = 0;
      return;
    end
    exp_v = act[d] && !bub[d];
    check_eq({p, "_valid"}, v, exp_v);
    check_eq({p, "_busy"}, b, act[d]);
    check_eq({p, "_done"}, dn, dexp[d]);
    if (exp_v) begin
      check_eq({p, "_idx"}, ix, 128'(n_exp[d]));
      check_eq({p, "_rk"}, k, ktab[d][n_exp[d]]);
    end
    dexp[d] = 0;
    if (abort) begin
      act[d] = 0; bub[d] = 0;
    end else if (!act[d]) begin
      if (start) begin
        act[d] = 1; bub[d] = 0; n_exp[d] = 0;
        expand(d, key_in);
      end
    end else if (bub[d]) begin
      bub[d] = 0;
    end else if (rk_ready) begin
      if (n_exp[d] == 10) begin
        act[d] = 0; dexp[d] = 1;
      end else begin
        n_exp[d]++;
        bub[d] = (d == 1);
      end
    end
  endtask

  always @(negedge clk) mon_step(0, v0, rk0, idx0, busy0, done0);
  always @(negedge clk) mon_step(1, v1, rk1, idx1, busy1, done1);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One expansion run; starts in the current cycle and returns in the first
  // cycle where both instances are idle (possibly their done cycle).
  task automatic run(input logic [127:0] key, input int rdy_pct, input int abort_idx,
                     input int start_idx, input int rst_idx);
    bit fin;
    fin      = 0;
    start    = 1'b1;
    key_in   = key;
    rk_ready = ($urandom_range(99) < rdy_pct);
    for (int c = 0; c < 400; c++) begin
      tick();
      start = 1'b0;
      abort = 1'b0;
      if (!busy0 && !busy1) begin
        fin = 1;
        break;
      end
      rk_ready = ($urandom_range(99) < rdy_pct);
      if (abort_idx >= 0 && v0 && idx0 == abort_idx[3:0]) begin
        abort    = 1'b1;
        rk_ready = 1'b1;
      end
      if (start_idx >= 0 && v0 && idx0 == start_idx[3:0]) begin
        start  = 1'b1;
        key_in = rand_key();
      end
      if (rst_idx >= 0 && v0 && idx0 == rst_idx[3:0]) begin
        rst_n = 1'b0;
        #1;
        check_eq("arst_rk0", rk0, 0);
        check_eq("arst_idx0", idx0, 0);
        check_eq("arst_valid0", v0, 0);
        check_eq("arst_busy0", busy0, 0);
        check_eq("arst_rk1", rk1, 0);
        check_eq("arst_busy1", busy1, 0);
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        fin   = 1;
        break;
      end
    end
    check_eq("run_finished", fin, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0, first1, last1, idx10c, donec, pct, aidx;
    bit finA;
    build_sbox();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; key_in = '0; rk_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_rk", rk0, 0);
    check_eq("reset_idx", idx0, 0);
    check_eq("reset_valid", v0, 0);
    check_eq("reset_busy", busy0, 0);
    check_eq("reset_done", done0, 0);
    tick();
    rst_n = 1'b1;

    // Known-answer run, ready tied high.
    start = 1'b1; key_in = c_FIPS; rk_ready = 1'b1;
    tick();
    start = 1'b0;
    cnt0 = 0; first1 = -1; last1 = -1; idx10c = -1; donec = -1; finA = 0;
    for (int c = 0; c < 60; c++) begin
      if (v0) begin
        cnt0++;
        if (idx0 == 4'd1) check_eq("kat_idx1", rk0, c_K1);
        if (idx0 == 4'd10) begin
          check_eq("kat_idx10", rk0, c_K10);
          idx10c = c;
        end
      end
      if (done0) donec = c;
      if (v1 && first1 < 0) first1 = c;
      if (v1 && idx1 == 4'd10) last1 = c;
      if (!busy0 && !busy1) begin
        finA = 1;
        break;
      end
      tick();
    end
    check_eq("kat_finished", finA, 1);
    check_eq("p0_valid_cycles", cnt0, 11);
    check_eq("p0_done_after_idx10", donec, idx10c + 1);
    check_eq("p1_idx10_distance", last1 - first1, 20);
    check_eq("hold_rk0", rk0, c_K10);
    check_eq("hold_idx0", idx0, 10);
    check_eq("hold_rk1", rk1, c_K10);

    // Back-pressure, started in the done cycle of the pipelined instance.
    run(c_FIPS, 50, -1, -1, -1);
    // Abort on the idx4 transfer, then restart with the same key.
    run(c_FIPS, 60, 4, -1, -1);
    run(c_FIPS, 100, -1, -1, -1);
    // Foreign start while busy must be ignored.
    run(c_FIPS, 70, -1, 5, -1);
    // Asynchronous reset mid-run, then a fresh run to completion.
    run(rand_key(), 70, -1, -1, 7);
    run(rand_key(), 50, -1, -1, -1);

    // Start together with abort in IDLE must not launch a run.
    start = 1'b1; abort = 1'b1; key_in = rand_key();
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    check_eq("start_abort_busy", busy0, 0);

    for (int r = 0; r < 8; r++) begin
      pct  = $urandom_range(100, 25);
      aidx = ($urandom_range(3) == 0) ? int'($urandom_range(10)) : -1;
      run(rand_key(), pct, aidx, -1, -1);
    end
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
